// File: rtl/gpio_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_reg_ctrl
// Description : Register-bus controller for the 16-pin GPIO vector block.
//               Holds the pin configuration registers, synchronises pin
//               readback and the raw GPIO interrupt lines, latches interrupt
//               edges into sticky W1C status bits, and raises one maskable
//               registered CPU interrupt.
//
// Ports       : clk, reset          - clock, async active-high reset
//               req/we/addr/wdata   - CPU request side (held until ack)
//               ack/rdata           - CPU response side
//               gpio_enable         - GPIO Enable (active low)
//               gpio_function       - GPIO Function (1 = output)
//               gpio_data_out       - GPIO Data_out
//               gpio_pc_mask        - GPIO Pin_Change_Mask
//               gpio_int_mask       - GPIO Int_Mask
//               gpio_data_in        - GPIO Data_in (asynchronous)
//               gpio_irq_pc         - GPIO IRQ_PIN_CHANGE
//               gpio_irq_int        - GPIO IRQ_INT (bit0 pin14, bit1 pin15)
//               irq                 - CPU interrupt
//
// Options     : GPIO_REG_CTRL_EVCNT_EN - address 7 becomes an 8-bit
//               saturating, clear-on-read event counter.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_reg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              ack,
    output logic [15:0]       rdata,
    output logic              gpio_enable,
    output logic [15:0]       gpio_function,
    output logic [15:0]       gpio_data_out,
    output logic [15:0]       gpio_pc_mask,
    output logic [1:0]        gpio_int_mask,
    input  logic [15:0]       gpio_data_in,
    input  logic              gpio_irq_pc,
    input  logic [1:0]        gpio_irq_int,
    output logic              irq
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    localparam logic [ADDR_W-1:0] c_ADDR_FUNC   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_DOUT   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_PCMASK = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_ADDR_DIN    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] c_ADDR_IRQEN  = ADDR_W'(6);
`ifdef GPIO_REG_CTRL_EVCNT_EN
    localparam logic [ADDR_W-1:0] c_ADDR_EVCNT  = ADDR_W'(7);
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_ack;
    logic [15:0]       r_rdata;

    logic [15:0]       r_func;
    logic [15:0]       r_dout;
    logic [15:0]       r_pcmask;
    logic [2:0]        r_ctrl;
    logic [2:0]        r_status;
    logic [2:0]        r_irqen;
    logic              r_irq;

    logic [15:0]       r_din_sync [SYNC_STAGES];
    logic [2:0]        r_irq_sync [SYNC_STAGES];
    logic [2:0]        r_irq_prev;

    logic [15:0]       w_din_s;
    logic [2:0]        w_irq_s;
    logic [2:0]        w_status_set;
    logic [2:0]        w_status_clr;
    logic              w_wr;
    logic              w_rd;
    logic [15:0]       w_rd_val;

    // ---------------------------------------------------------------- sync
    // IRQ lines are bundled as {int15, int14, pc} so their positions line up
    // directly with the STATUS bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_din_sync[i] <= '0;
                r_irq_sync[i] <= '0;
            end
            r_irq_prev <= '0;
        end else begin
            r_din_sync[0] <= gpio_data_in;
            r_irq_sync[0] <= {gpio_irq_int, gpio_irq_pc};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_din_sync[i] <= r_din_sync[i-1];
                r_irq_sync[i] <= r_irq_sync[i-1];
            end
            r_irq_prev <= w_irq_s;
        end
    end

    assign w_din_s      = r_din_sync[SYNC_STAGES-1];
    assign w_irq_s      = r_irq_sync[SYNC_STAGES-1];
    assign w_status_set = w_irq_s & ~r_irq_prev;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (req) w_state_nxt = c_ST_ACCESS;
            c_ST_ACCESS: w_state_nxt = c_ST_RESP;
            c_ST_RESP:   if (!req) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_wr         = (r_state == c_ST_ACCESS) &&  r_we;
    assign w_rd         = (r_state == c_ST_ACCESS) && !r_we;
    assign w_status_clr = (w_wr && r_addr == c_ADDR_STATUS) ? r_wdata[2:0] : 3'b000;

`ifdef GPIO_REG_CTRL_EVCNT_EN
    logic [7:0] r_evcnt;
    logic       w_any_set;

    assign w_any_set = |w_status_set;

    // A read clears the count in the ACCESS cycle; an event landing in that
    // same cycle is kept as the first count of the new window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evcnt <= '0;
        end else if (w_rd && r_addr == c_ADDR_EVCNT) begin
            r_evcnt <= {7'b0, w_any_set};
        end else if (w_any_set && r_evcnt != 8'hFF) begin
            r_evcnt <= r_evcnt + 8'd1;
        end
    end
`endif

    // ---------------------------------------------------------------- read mux
    always_comb begin
        w_rd_val = '0;
        case (r_addr)
            c_ADDR_FUNC:   w_rd_val = r_func;
            c_ADDR_DOUT:   w_rd_val = r_dout;
            c_ADDR_PCMASK: w_rd_val = r_pcmask;
            c_ADDR_CTRL:   w_rd_val = {13'b0, r_ctrl};
            c_ADDR_DIN:    w_rd_val = w_din_s;
            c_ADDR_STATUS: w_rd_val = {13'b0, r_status};
            c_ADDR_IRQEN:  w_rd_val = {13'b0, r_irqen};
`ifdef GPIO_REG_CTRL_EVCNT_EN
            c_ADDR_EVCNT:  w_rd_val = {8'b0, r_evcnt};
`endif
            default:       w_rd_val = '0;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_func   <= '0;
            r_dout   <= '0;
            r_pcmask <= '0;
            r_ctrl   <= '0;
            r_status <= '0;
            r_irqen  <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            r_ack <= (w_state_nxt == c_ST_RESP);
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
            if (w_wr) begin
                case (r_addr)
                    c_ADDR_FUNC:   r_func   <= r_wdata;
                    c_ADDR_DOUT:   r_dout   <= r_wdata;
                    c_ADDR_PCMASK: r_pcmask <= r_wdata;
                    c_ADDR_CTRL:   r_ctrl   <= r_wdata[2:0];
                    c_ADDR_IRQEN:  r_irqen  <= r_wdata[2:0];
                    default:       ;
                endcase
            end
            // Set is OR-ed after the clear so a coincident event wins.
            r_status <= (r_status & ~w_status_clr) | w_status_set;
            r_irq    <= |(r_status & r_irqen);
        end
    end

    assign ack           = r_ack;
    assign rdata         = r_rdata;
    assign gpio_enable   = ~r_ctrl[0];
    assign gpio_int_mask = r_ctrl[2:1];
    assign gpio_function = r_func;
    assign gpio_data_out = r_dout;
    assign gpio_pc_mask  = r_pcmask;
    assign irq           = r_irq;

endmodule
`default_nettype wire
